pipe_ctrl_ng: RTL
=================

PIPE_CTRL_NG -- requirements
Module: pipe_ctrl_ng

Interface
REQ-001 SHALL have parameter NSTAGE, default 6; number of pipeline stages; stall bit 0 = PC, bit NSTAGE-1 = writeback.
REQ-002 SHALL have parameter FLUSH_LEN, default 1, range 1..15; number of cycles flush is held per exception.
REQ-003 SHALL have parameter EXC_BASE, default 32'h00000000; exception vector base.
REQ-004 SHALL have parameter WDOG_LIMIT, default 1024, range 1..65535; stall watchdog threshold.
REQ-005 SHALL have port clk, input, 1; the only clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; synchronous, active-low reset.
REQ-007 SHALL have port stallreq_i, input, NSTAGE; bit k is the stall request from stage k.
REQ-008 SHALL have port exc_valid_i, input, 1; an exception is presented this cycle.
REQ-009 SHALL have port exc_code_i, input, 5; exception code, qualified by exc_valid_i.
REQ-010 SHALL have port cp0_epc_i, input, 32; return address for eret.
REQ-011 SHALL have port stall, output, NSTAGE; per-stage hold.
REQ-012 SHALL have port flush, output, 1; pipeline flush.
REQ-013 SHALL have port new_pc, output, 32; redirect target, valid while flush=1.
REQ-014 SHALL have port busy, output, 1; high while the FSM is in FLUSH.
REQ-015 SHALL have port wdog_o, output, 1; stall watchdog flag.

Function
REQ-016 SHALL implement a two-state FSM: RUN and FLUSH.
REQ-017 In RUN, an exception (exc_valid_i=1) at cycle t SHALL register new_pc, move the FSM to FLUSH, and assert flush=1 for cycles t+1 to t+FLUSH_LEN.
REQ-018 Flush duration SHALL be counted by a 4-bit down-counter; the FSM SHALL return to RUN after the last flush cycle.
REQ-019 new_pc vector selection by exc_code_i:
 - 0x01 (interrupt) -> EXC_BASE+0x20;
 - 0x0e (eret) -> cp0_epc_i sampled at cycle t;
 - 0x08, 0x0a, 0x0c, 0x0d, and any other code -> EXC_BASE+0x40.
REQ-020 new_pc SHALL hold its value during FLUSH and SHALL be 32'h0 in RUN.
REQ-021 In FLUSH, exc_valid_i SHALL be ignored; no re-latch and no extension of the flush.
REQ-022 Stall SHALL be combinational from stallreq_i: with k = highest set index, stall[j]=1 for all j<=k and 0 otherwise.
REQ-023 stall SHALL be forced all-zero when any of these holds: exc_valid_i=1 in RUN, FSM in FLUSH, or rst=0.
REQ-024 With stallreq_i all-zero, stall SHALL be all-zero.
REQ-025 busy SHALL equal (state==FLUSH).
REQ-026 An exception at the cycle the FSM returns to RUN SHALL be accepted normally, giving back-to-back flush windows.

Reset
REQ-027 On rst=0 at a clock edge, the FSM SHALL go to RUN, the counter to 0, flush to 0, new_pc to 32'h0, and the watchdog count to 0.
REQ-028 Reset mid-FLUSH SHALL abort the flush; flush=0 from the next cycle.

Configuration
REQ-029 With macro STALL_WDOG_EN defined, a 16-bit saturating counter SHALL increment each cycle stall!=0 and clear on any cycle stall==0.
REQ-030 With STALL_WDOG_EN defined, wdog_o SHALL be registered and equal 1 while the count is >= WDOG_LIMIT.
REQ-031 Without STALL_WDOG_EN, there SHALL be no counter and wdog_o SHALL be tied to 0.

Structure
REQ-032 Exception codes (0x01, 0x08, 0x0a, 0x0c, 0x0d, 0x0e), vector offsets (0x20, 0x40) and FSM state encodings SHALL live in the shared defines package.
REQ-033 The stall-mask generator (highest-set-bit to thermometer mask) SHALL be one sub-module, stall_mask, parameterised by NSTAGE.

Verification
REQ-034 NSTAGE=6, stallreq_i=6'b000100 -> stall=6'b000111; stallreq_i=6'b001100 -> stall=6'b001111.
REQ-035 FLUSH_LEN=3, EXC_BASE=0, exc_code_i=0x08 at t -> flush=1 and new_pc=0x40 at t+1..t+3; busy=1 over the same cycles; flush=0 at t+4.
REQ-036 exc_code_i=0x0e with cp0_epc_i=0x1234 at t, cp0_epc_i changed at t+1 -> new_pc=0x1234 throughout the flush.
REQ-037 Exception at t, second exception at t+1 while FLUSH_LEN=3 -> single 3-cycle window; new_pc still from the first exception.
REQ-038 stallreq_i=6'b001000 with exc_valid_i=1 in the same cycle -> stall=0 that cycle; flush=1 at the next cycle.
REQ-039 STALL_WDOG_EN, WDOG_LIMIT=4, stall held for 6 cycles -> wdog_o=1 after the 4th stalled cycle; one unstalled cycle -> wdog_o=0.

Source files
------------

// File: rtl/pipe_ctrl_ng_pkg.sv
// Shared definitions for the pipeline controller: exception codes, vector
// offsets, FSM state encoding and the exception vector selection helper.
package pipe_ctrl_ng_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [31:0] VEC_OFS_INT = 32'h0000_0020;
    localparam logic [31:0] VEC_OFS_GEN = 32'h0000_0040;

    // Unlisted codes share the general exception vector.
    function automatic logic [31:0] exc_vector(input logic [31:0] base,
                                               input logic [4:0]  code,
                                               input logic [31:0] epc);
        logic [31:0] vec;
        case (code)
            EXC_INT:                         vec = base + VEC_OFS_INT;
            EXC_ERET:                        vec = epc;
            EXC_SYS, EXC_RI, EXC_OV, EXC_TR: vec = base + VEC_OFS_GEN;
            default:                         vec = base + VEC_OFS_GEN;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_ng_stall_mask.sv
// Thermometer stall mask: every stage at or below the highest requesting
// stage is held.
module stall_mask #(
    parameter int NSTAGE = 6
) (
    input  logic [NSTAGE-1:0] req,
    output logic [NSTAGE-1:0] mask
);

    for (genvar j = 0; j < NSTAGE; j++) begin : g_mask
        assign mask[j] = |req[NSTAGE-1:j];
    end

endmodule

// File: rtl/pipe_ctrl_ng.sv
// Pipeline stall/flush controller with exception redirect.
// Optional stall watchdog enabled by defining STALL_WDOG_EN.
module pipe_ctrl_ng
    import pipe_ctrl_ng_pkg::*;
#(
    parameter int          NSTAGE     = 6,
    parameter int          FLUSH_LEN  = 1,
    parameter logic [31:0] EXC_BASE   = 32'h0000_0000,
    parameter int          WDOG_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              exc_valid_i,
    input  logic [4:0]        exc_code_i,
    input  logic [31:0]       cp0_epc_i,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              busy,
    output logic              wdog_o
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_LEN - 1);

    state_e            state_r;
    logic [3:0]        cnt_r;
    logic              flush_r;
    logic              busy_r;
    logic [31:0]       new_pc_r;
    logic [NSTAGE-1:0] mask_s;

    stall_mask #(.NSTAGE(NSTAGE)) u_stall_mask (
        .req  (stallreq_i),
        .mask (mask_s)
    );

    // Stall mask, suppressed during reset, flush, or an accepted exception.
    always_comb begin
        stall = {NSTAGE{1'b0}};
        if (!rst) begin
            stall = {NSTAGE{1'b0}};
        end else if (state_r == ST_FLUSH) begin
            stall = {NSTAGE{1'b0}};
        end else if (exc_valid_i) begin
            stall = {NSTAGE{1'b0}};
        end else begin
            stall = mask_s;
        end
    end

    // RUN/FLUSH state machine with flush window counter and redirect target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_RUN;
            cnt_r    <= 4'd0;
            flush_r  <= 1'b0;
            busy_r   <= 1'b0;
            new_pc_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_valid_i) begin
                        state_r  <= ST_FLUSH;
                        cnt_r    <= CNT_LOAD;
                        flush_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        new_pc_r <= exc_vector(EXC_BASE, exc_code_i, cp0_epc_i);
                    end else begin
                        cnt_r    <= 4'd0;
                        flush_r  <= 1'b0;
                        busy_r   <= 1'b0;
                        new_pc_r <= 32'h0000_0000;
                    end
                end
                ST_FLUSH: begin
                    // New exceptions are deliberately not looked at here.
                    if (cnt_r == 4'd0) begin
                        state_r  <= ST_RUN;
                        flush_r  <= 1'b0;
                        busy_r   <= 1'b0;
                        new_pc_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    cnt_r    <= 4'd0;
                    flush_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    new_pc_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign flush  = flush_r;
    assign busy   = busy_r;
    assign new_pc = new_pc_r;

`ifdef STALL_WDOG_EN
    localparam logic [15:0] WDOG_LIM = 16'(WDOG_LIMIT);

    logic [15:0] wcnt_r;
    logic [15:0] wcnt_next_s;
    logic        wdog_r;

    // Saturating count of consecutive stalled cycles.
    always_comb begin
        wcnt_next_s = 16'd0;
        if (stall == {NSTAGE{1'b0}}) begin
            wcnt_next_s = 16'd0;
        end else if (wcnt_r == 16'hFFFF) begin
            wcnt_next_s = wcnt_r;
        end else begin
            wcnt_next_s = wcnt_r + 16'd1;
        end
    end

    // Flag is registered from the next count so it tracks the count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_r <= 16'd0;
            wdog_r <= 1'b0;
        end else begin
            wcnt_r <= wcnt_next_s;
            wdog_r <= (wcnt_next_s >= WDOG_LIM);
        end
    end

    assign wdog_o = wdog_r;
`else
    assign wdog_o = 1'b0;
`endif

endmodule
